// File: rtl/sram_1rw_sync_wrapper.sv
// Single-port synchronous SRAM wrapper: behavioural array, post-reset INIT_VAL sweep, masked writes, read-valid strobe.
// Define SRAM_RDATA_REG_EN to add an output register stage (read latency 2 instead of 1).
module sram_1rw_sync_wrapper #(
  parameter int unsigned      DEPTH     = 64,
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      MASK_GRAN = 8,
  parameter logic [WIDTH-1:0] INIT_VAL  = '0,
  localparam int unsigned     NLANES    = WIDTH / MASK_GRAN,
  localparam int unsigned     ADDR_W    = $clog2(DEPTH)
) (
  input  logic              RW0_clk,
  input  logic              RW0_rst_n,
  input  logic [ADDR_W-1:0] RW0_addr,
  input  logic              RW0_en,
  input  logic              RW0_wmode,
  input  logic [NLANES-1:0] RW0_wmask,
  input  logic [WIDTH-1:0]  RW0_wdata,
  output logic [WIDTH-1:0]  RW0_rdata,
  output logic              RW0_rvalid,
  output logic              init_busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    S_INIT,
    S_READY
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              req_rd, req_wr;
  logic              in_range;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [WIDTH-1:0]  rd_data_q;
  logic              rd_valid_q;

  assign init_busy = (state_q == S_INIT);
  // Only reachable as false when DEPTH is not a power of two.
  assign in_range  = (32'(RW0_addr) < DEPTH);

  always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
    if (!RW0_rst_n) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_rd  = 1'b0;
    req_wr  = 1'b0;
    case (state_q)
      S_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = S_READY;
          cnt_d   = '0;
        end
      end
      S_READY: begin
        if (RW0_en) begin
          req_wr = RW0_wmode;
          req_rd = !RW0_wmode;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge RW0_clk) begin
    if (init_busy) begin
      mem[cnt_q] <= INIT_VAL;
    end else if (req_wr && in_range) begin
      for (int unsigned l = 0; l < NLANES; l++) begin
        if (RW0_wmask[l]) begin
          mem[RW0_addr][l*MASK_GRAN +: MASK_GRAN] <= RW0_wdata[l*MASK_GRAN +: MASK_GRAN];
        end
      end
    end
  end

  always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
    if (!RW0_rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= req_rd;
      if (req_rd) begin
        rd_data_q <= in_range ? mem[RW0_addr] : '0;
      end
    end
  end

`ifdef SRAM_RDATA_REG_EN
  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q;

  // Output stage captures only valid reads, so it holds the last read value like stage 1.
  always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
    if (!RW0_rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= rd_valid_q;
      if (rd_valid_q) begin
        out_data_q <= rd_data_q;
      end
    end
  end

  assign RW0_rdata  = out_data_q;
  assign RW0_rvalid = out_valid_q;
`else
  assign RW0_rdata  = rd_data_q;
  assign RW0_rvalid = rd_valid_q;
`endif

endmodule

// File: tb/tb_sram_1rw_sync_wrapper.sv
// Bench for sram_1rw_sync_wrapper: directed vector table, init/reset sequences, and random traffic against an array model.
module tb_sram_1rw_sync_wrapper;

`ifdef SRAM_RDATA_REG_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif
  localparam logic [31:0] INIT2 = 32'hC0FFEE00;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  addr, addr2;
  logic        en, en2, wmode, wmode2;
  logic [3:0]  wmask, wmask2;
  logic [31:0] wdata, wdata2;
  logic [31:0] rdata, rdata2;
  logic        rvalid, rvalid2, busy, busy2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sram_1rw_sync_wrapper #(.DEPTH(64), .WIDTH(32), .MASK_GRAN(8), .INIT_VAL(32'h0)) dut (
    .RW0_clk(clk), .RW0_rst_n(rst_n), .RW0_addr(addr), .RW0_en(en), .RW0_wmode(wmode),
    .RW0_wmask(wmask), .RW0_wdata(wdata), .RW0_rdata(rdata), .RW0_rvalid(rvalid), .init_busy(busy)
  );

  sram_1rw_sync_wrapper #(.DEPTH(48), .WIDTH(32), .MASK_GRAN(8), .INIT_VAL(INIT2)) dut48 (
    .RW0_clk(clk), .RW0_rst_n(rst_n), .RW0_addr(addr2), .RW0_en(en2), .RW0_wmode(wmode2),
    .RW0_wmask(wmask2), .RW0_wdata(wdata2), .RW0_rdata(rdata2), .RW0_rvalid(rvalid2), .init_busy(busy2)
  );

  // Reference model for the 64-word instance.
  logic [31:0] m_mem [64];
  int unsigned m_init_left, m2_init_left;
  logic [31:0] m_last;
  logic        m_pv [L];
  logic [31:0] m_pd [L];

  typedef struct {
    bit          sel;
    bit          en;
    bit          wmode;
    logic [5:0]  addr;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    bit          ev;
    logic [31:0] ed;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit sel, bit e, bit wm, logic [5:0] a, logic [3:0] m,
                              logic [31:0] d, bit ev, logic [31:0] ed);
    vec_t v;
    v.sel = sel; v.en = e; v.wmode = wm; v.addr = a; v.wmask = m; v.wdata = d; v.ev = ev; v.ed = ed;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_init_left  = 64;
    m2_init_left = 48;
    m_last       = '0;
    for (int i = 0; i < L; i++) begin
      m_pv[i] = 1'b0;
      m_pd[i] = '0;
    end
  endtask

  task automatic set_idle();
    en = 1'b0; wmode = 1'b0; addr = '0; wmask = '0; wdata = '0;
    en2 = 1'b0; wmode2 = 1'b0; addr2 = '0; wmask2 = '0; wdata2 = '0;
  endtask

  task automatic drive(vec_t v);
    en  = v.en && !v.sel; wmode  = v.wmode; addr  = v.addr; wmask  = v.wmask; wdata  = v.wdata;
    en2 = v.en && v.sel;  wmode2 = v.wmode; addr2 = v.addr; wmask2 = v.wmask; wdata2 = v.wdata;
  endtask

  // One clock edge: advance the model with the inputs present at the edge, then compare 1 time unit later.
  task automatic tick();
    bit v;
    @(posedge clk);
    v = 1'b0;
    if (m_init_left != 0) begin
      m_mem[64 - m_init_left] = 32'h0;
      m_init_left--;
    end else if (en) begin
      if (wmode) begin
        for (int l = 0; l < 4; l++)
          if (wmask[l]) m_mem[addr][l*8 +: 8] = wdata[l*8 +: 8];
      end else begin
        v = 1'b1;
        m_last = m_mem[addr];
      end
    end
    if (m2_init_left != 0) m2_init_left--;
    for (int i = L - 1; i > 0; i--) begin
      m_pv[i] = m_pv[i-1];
      m_pd[i] = m_pd[i-1];
    end
    m_pv[0] = v;
    m_pd[0] = m_last;
    #1;
    check("rvalid", 32'(rvalid), 32'(m_pv[L-1]));
    check("rdata", rdata, m_pd[L-1]);
    check("init_busy", 32'(busy), (m_init_left != 0) ? 32'd1 : 32'd0);
    check("init_busy48", 32'(busy2), (m2_init_left != 0) ? 32'd1 : 32'd0);
  endtask

  // Called 1 time unit after an edge: assert reset, check outputs before any edge, then release off-edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_rdata", rdata, 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_rdata48", rdata2, 32'h0);
    @(posedge clk);
    #1;
    check("rst_held_busy", 32'(busy), 32'd1);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    int j;
    for (int i = 0; i < 64; i++) m_mem[i] = 32'hXXXXXXXX;

    tbl.push_back(mk(0, 1, 0, 6'd2,  4'h0, 32'h0,        1, 32'h0));
    tbl.push_back(mk(0, 1, 0, 6'd0,  4'h0, 32'h0,        1, 32'h0));
    tbl.push_back(mk(0, 1, 0, 6'd31, 4'h0, 32'h0,        1, 32'h0));
    tbl.push_back(mk(0, 1, 0, 6'd63, 4'h0, 32'h0,        1, 32'h0));
    tbl.push_back(mk(0, 1, 1, 6'd5,  4'hF, 32'hDEADBEEF, 0, 32'h0));
    tbl.push_back(mk(0, 1, 1, 6'd5,  4'h5, 32'h11223344, 0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 6'd5,  4'h0, 32'h0,        1, 32'hDE22BE44));
    tbl.push_back(mk(0, 1, 1, 6'd7,  4'hF, 32'hA5A5A5A5, 0, 32'hDE22BE44));
    tbl.push_back(mk(0, 1, 0, 6'd7,  4'h0, 32'h0,        1, 32'hA5A5A5A5));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 0, 1, 6'd7, 4'hF, 32'hFFFFFFFF, 0, 32'hA5A5A5A5));
    tbl.push_back(mk(0, 1, 1, 6'd7,  4'hF, 32'h0,        0, 32'hA5A5A5A5));
    tbl.push_back(mk(0, 1, 0, 6'd7,  4'h0, 32'h0,        1, 32'h0));
    tbl.push_back(mk(0, 1, 1, 6'd9,  4'h0, 32'h12345678, 0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 6'd9,  4'h0, 32'h0,        1, 32'h0));
    tbl.push_back(mk(0, 1, 1, 6'd1,  4'hF, 32'h1,        0, 32'h0));
    tbl.push_back(mk(0, 1, 1, 6'd2,  4'hF, 32'h2,        0, 32'h0));
    tbl.push_back(mk(0, 1, 1, 6'd3,  4'hF, 32'h3,        0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 6'd1,  4'h0, 32'h0,        1, 32'h1));
    tbl.push_back(mk(0, 1, 0, 6'd2,  4'h0, 32'h0,        1, 32'h2));
    tbl.push_back(mk(0, 1, 0, 6'd3,  4'h0, 32'h0,        1, 32'h3));
    tbl.push_back(mk(0, 0, 0, 6'd0,  4'h0, 32'h0,        0, 32'h3));
    tbl.push_back(mk(1, 1, 1, 6'd50, 4'hF, 32'h12345678, 0, 32'h0));
    tbl.push_back(mk(1, 1, 0, 6'd47, 4'h0, 32'h0,        1, INIT2));
    tbl.push_back(mk(1, 1, 0, 6'd50, 4'h0, 32'h0,        1, 32'h0));
    tbl.push_back(mk(1, 1, 0, 6'd18, 4'h0, 32'h0,        1, INIT2));
    tbl.push_back(mk(1, 1, 0, 6'd2,  4'h0, 32'h0,        1, INIT2));
    tbl.push_back(mk(1, 0, 0, 6'd0,  4'h0, 32'h0,        0, INIT2));
    tbl.push_back(mk(1, 0, 0, 6'd0,  4'h0, 32'h0,        0, INIT2));

    set_idle();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // First sweep, with a write attempted on sweep cycle 10.
    cnt = 0;
    while (busy && cnt < 200) begin
      set_idle();
      if (cnt == 9) begin
        en = 1'b1; wmode = 1'b1; addr = 6'd2; wmask = 4'hF; wdata = 32'hFFFFFFFF;
      end
      tick();
      cnt++;
    end
    check("init_cycles", cnt, 64);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      tick();
      if (i >= L - 1) begin
        j = i - L + 1;
        if (tbl[j].sel) begin
          check($sformatf("vec%0d_rvalid48", j), 32'(rvalid2), 32'(tbl[j].ev));
          check($sformatf("vec%0d_rdata48", j), rdata2, tbl[j].ed);
        end else begin
          check($sformatf("vec%0d_rvalid", j), 32'(rvalid), 32'(tbl[j].ev));
          check($sformatf("vec%0d_rdata", j), rdata, tbl[j].ed);
        end
      end
    end

    for (int i = 0; i < 400; i++) begin
      set_idle();
      en    = ($urandom_range(0, 3) != 0);
      wmode = $urandom_range(0, 1) == 1;
      addr  = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
      wmask = 4'($urandom);
      wdata = $urandom;
      tick();
    end

    set_idle();
    en = 1'b1; wmode = 1'b1; addr = 6'd5; wmask = 4'hF; wdata = 32'hCAFEF00D;
    tick();
    wmode = 1'b0;
    tick();
    set_idle();
    tick();
    check("pre_reset_rdata", rdata, 32'hCAFEF00D);

    do_reset();
    for (int i = 0; i < 20; i++) tick();
    do_reset();
    cnt = 0;
    while (busy && cnt < 200) begin
      tick();
      cnt++;
    end
    check("restart_init_cycles", cnt, 64);

    en = 1'b1; wmode = 1'b0; addr = 6'd5;
    tick();
    set_idle();
    tick();
    check("post_sweep_rdata", rdata, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sram_1rw_sync_wrapper.md
Name: sram_1rw_sync_wrapper

Overview:
- Parametrised single-port (1RW) synchronous SRAM wrapper with a behavioural array.
- It generalises the team's fixed-size cache data-array wrappers in three ways:
  - depth, width and write-mask granularity are parameters;
  - a post-reset initialisation sweep writes a known value to every word;
  - a read-valid strobe and held read data are provided.
- Used for tag, data and scratch arrays in the tiny core wherever no hard macro exists.

Parameters:
- DEPTH, 64: number of words; any value >= 2; need not be a power of two.
- WIDTH, 32: bits per word; must be a multiple of MASK_GRAN.
- MASK_GRAN, 8: bits per write-mask lane; NLANES = WIDTH/MASK_GRAN.
- INIT_VAL, 0: WIDTH-bit value written to every word during the init sweep.
- ADDR_W (localparam): $clog2(DEPTH).

Ports:
- RW0_clk  in  1  clock; all state updates on rising edge.
- RW0_rst_n  in  1  asynchronous, active-low reset.
- RW0_addr  in  ADDR_W  word address.
- RW0_en  in  1  access enable, active high.
- RW0_wmode  in  1  1 = write, 0 = read (qualified by RW0_en).
- RW0_wmask  in  NLANES  per-lane write enable; lane i covers data bits [i*MASK_GRAN +: MASK_GRAN].
- RW0_wdata  in  WIDTH  write data.
- RW0_rdata  out  WIDTH  read data.
- RW0_rvalid  out  1  one-cycle strobe: RW0_rdata is fresh this cycle.
- init_busy  out  1  high while the init sweep runs; all requests are ignored while high.

Behaviour:
- Reset (RW0_rst_n low, asynchronous):
  - state = INIT, sweep counter = 0, init_busy = 1;
  - RW0_rdata = 0, RW0_rvalid = 0;
  - array contents are not reset directly.
- FSM state INIT:
  - every cycle writes INIT_VAL (all lanes) to word[counter] and increments the counter;
  - the cycle that writes word DEPTH-1 sets state = READY, so init_busy falls at that edge;
  - the sweep takes exactly DEPTH cycles after reset release;
  - RW0_en is ignored: no array update, no RW0_rvalid.
  - Reset asserted mid-sweep restarts the sweep at address 0.
- FSM state READY (left only by reset):
  - Read: RW0_en=1, RW0_wmode=0. At the same edge, RW0_rdata <= word[RW0_addr] and RW0_rvalid <= 1. Data and strobe are visible in the cycle after the request (latency 1).
  - Write: RW0_en=1, RW0_wmode=1. At the edge, only lanes with RW0_wmask[i]=1 are updated. Wmask all-zero is a legal no-op. A write does not change RW0_rdata. RW0_rvalid <= 0.
  - Idle: RW0_en=0. RW0_rvalid <= 0 and RW0_rdata holds its last read value indefinitely.
  - Back-to-back reads: one result per cycle, with RW0_rvalid held high continuously.
  - Read of an address just written in the previous cycle returns the new data (no hazard; single port).
- Out-of-range address (RW0_addr >= DEPTH, possible only when DEPTH is not a power of two):
  - write: dropped, array unchanged;
  - read: RW0_rdata <= 0 and RW0_rvalid <= 1.
- Width rules: RW0_wdata and RW0_rdata are exactly WIDTH bits wide; no sign or zero extension.
- X safety: RW0_wmode and RW0_wmask are don't-care when RW0_en=0.

Optional Feature:
- SRAM_RDATA_REG_EN defined:
  - an output register stage is added after the array read, so read latency = 2;
  - RW0_rvalid is delayed to match the data;
  - the pipeline is fully pipelined: back-to-back reads give back-to-back strobes;
  - both stages reset to 0; the output stage holds when no new valid data arrives.
- Not defined: latency 1 as in Behaviour.
- In both cases init_busy timing is identical.

Test Plan (DEPTH=64, WIDTH=32, MASK_GRAN=8 unless stated):
- Release reset -> init_busy high for exactly 64 cycles. Then read addr 0, 31 and 63 -> rdata=0x00000000, each with rvalid 1 cycle later.
- Write addr 5 = 0xDEADBEEF with wmask=4'hF, then addr 5 = 0x11223344 with wmask=4'b0101; read addr 5 -> 0xDE22BE44.
- Read addr 7 (holding 0xA5A5A5A5), then 3 idle cycles, then write addr 7 = 0 -> rdata stays 0xA5A5A5A5 throughout; rvalid high for exactly 1 cycle.
- Issue requests during the sweep: write addr 2 = 0xFFFFFFFF at cycle 10 of init -> ignored; after init, read addr 2 -> 0x0. Then assert reset at cycle 20 of a second sweep -> init_busy stays high for 64 cycles after release.
- DEPTH=48: write addr 50 = 0x12345678, then read addr 50 -> rdata=0, rvalid=1; read addr 47 -> INIT_VAL.
- With SRAM_RDATA_REG_EN: reads of addr 1, 2, 3 on consecutive cycles (preloaded 0x1, 0x2, 0x3) -> rvalid high on cycles +2, +3, +4 with rdata 0x1, 0x2, 0x3.
